amul_err_eval: RTL and testbench
================================

Name: amul_err_eval

Overview:
- Exhaustive-sweep error evaluator for the unsigned approximate multipliers in this library (8x8 by default).
- Drives every operand pair into an external combinational approximate multiplier and takes its product back on the same cycle.
- Compares each result against an internally computed exact product and accumulates error metrics.
- Sits as the stimulus/checker stage wrapped directly around one approximate multiplier instance. Used for on-chip characterisation (uniform-distribution error).

Parameters:
- W, 8, operand width; product width is 2W; the sweep covers 2^(2W) pairs.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- op_x  out  W  registered operand to the multiplier x input.
- op_y  out  W  registered operand to the multiplier y input.
- z_approx  in  2W  product returned combinationally by the multiplier for the current op_x/op_y.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when final results are valid.
- sum_ed  out  4W  sum of absolute error distances.
- sum_sq  out  6W  sum of squared error distances.
- max_ed  out  2W  maximum error distance.
- err_cnt  out  2W+1  count of pairs with a nonzero error.

Behaviour:
- Reset (rst_n=0 at a clock edge, any state, including mid-sweep):
  - FSM goes to IDLE.
  - op_x, op_y, busy, done, all accumulators, the index counter and the pipeline valids all become 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. Accumulators clear on the same edge; the index counter is set to 0.
  - start in RUN or DRAIN is ignored.
- RUN:
  - 2W-bit index i increments by 1 every cycle.
  - op_x = i[2W-1:W] and op_y = i[W-1:0], both registered from i. x is the outer loop and y the inner loop.
  - When the last pair (all ones) is issued, go to DRAIN. The counter does not wrap into a second pass.
- Stage 1 (same cycle that op_x/op_y are presented): ed = |op_x*op_y - z_approx|, 2W bits unsigned, registered with valid1.
- Stage 2: when valid1 is set, each metric updates as follows (no saturation is needed; widths are sized for the worst case):
  - sum_ed += ed
  - sum_sq += ed*ed (4W-bit product, zero-extended)
  - max_ed = max(max_ed, ed)
  - err_cnt += (ed != 0)
- DRAIN: lasts 2 cycles, flushing stages 1 and 2. Then go to DONE and pulse done for 1 cycle.
- DONE: outputs hold their values until the next start or reset. op_x/op_y hold their last values.
- Latency (start sampled at edge 0):
  - busy=1 from cycle 1.
  - Pair k is on op_x/op_y in cycle 1+k and is accumulated by the end of cycle 2+k.
  - done=1 and busy=0 in cycle 2^(2W)+3, which is cycle 65539 for W=8.
- Outputs are stable only when done=1 or in DONE. Intermediate values during RUN are informative only.
- z_approx must be a pure function of op_x/op_y. The block adds no register between op_x/op_y and z_approx.

Test Plan:
- Loopback with z_approx = op_x*op_y; start at cycle 0 -> done at cycle 65539; sum_ed=0, sum_sq=0, max_ed=0, err_cnt=0; busy high over cycles 1..65538.
- z_approx tied to 0 -> sum_ed=1,065,369,600; sum_sq=30,910,041,702,400; max_ed=65025; err_cnt=65025.
- z_approx tied to 16'hFFFF -> sum_ed=3,229,532,160; max_ed=65535; err_cnt=65536.
- z_approx = op_x*op_y+1 -> sum_ed=65536; sum_sq=65536; max_ed=1; err_cnt=65536.
- start pulsed again at cycle 30000 during RUN -> ignored; results identical to the undisturbed run.
  - A second start after DONE -> accumulators clear and the sweep repeats with the same done timing.
- rst_n=0 for one cycle at cycle 40000 -> next cycle everything is 0 and the FSM is in IDLE; no done pulse.
  - A following start completes normally with correct totals.

Source files
------------

// File: rtl/amul_err_eval.sv
// Exhaustive error evaluator for an external combinational approximate multiplier.
// Sweeps every operand pair, compares against the exact product, accumulates metrics.
module amul_err_eval #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   op_x,
  output logic [W-1:0]   op_y,
  input  logic [2*W-1:0] z_approx,
  output logic           busy,
  output logic           done,
  output logic [4*W-1:0] sum_ed,
  output logic [6*W-1:0] sum_sq,
  output logic [2*W-1:0] max_ed,
  output logic [2*W:0]   err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [2*W-1:0] idx_q;
  logic           drn_q;
  logic           done_q;
  logic           v1_q;
  logic [2*W-1:0] ed_q, ed_d;
  logic [2*W-1:0] exact;
  logic [4*W-1:0] sq;
  logic [4*W-1:0] sum_ed_q;
  logic [6*W-1:0] sum_sq_q;
  logic [2*W-1:0] max_ed_q;
  logic [2*W:0]   err_cnt_q;
  logic           go;
  logic           last;

  assign go   = start &&
                (state_q == S_IDLE || state_q == S_DONE);
  assign last = &idx_q;

  // The index register itself is the operand pair: x outer, y inner
  assign op_x = idx_q[2*W-1:W];
  assign op_y = idx_q[W-1:0];

  assign exact = (2*W)'(op_x) * (2*W)'(op_y);
  assign ed_d  = (exact >= z_approx) ? exact - z_approx
                                     : z_approx - exact;
  assign sq    = (4*W)'(ed_q) * (4*W)'(ed_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      drn_q     <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      ed_q      <= '0;
      sum_ed_q  <= '0;
      sum_sq_q  <= '0;
      max_ed_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (go)
        idx_q <= '0;
      else if (state_q == S_RUN && !last)
        idx_q <= idx_q + 1'b1;
      drn_q  <= (state_q == S_DRAIN) ? ~drn_q : 1'b0;
      done_q <= (state_q == S_DRAIN) && drn_q;
      v1_q   <= (state_q == S_RUN);
      ed_q   <= ed_d;
      if (go) begin
        sum_ed_q  <= '0;
        sum_sq_q  <= '0;
        max_ed_q  <= '0;
        err_cnt_q <= '0;
      end else if (v1_q) begin
        sum_ed_q  <= sum_ed_q + (4*W)'(ed_q);
        sum_sq_q  <= sum_sq_q + (6*W)'(sq);
        if (ed_q > max_ed_q)
          max_ed_q <= ed_q;
        err_cnt_q <= err_cnt_q + (2*W+1)'(ed_q != '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DRAIN;
      S_DRAIN: if (drn_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    done    = done_q;
    sum_ed  = sum_ed_q;
    sum_sq  = sum_sq_q;
    max_ed  = max_ed_q;
    err_cnt = err_cnt_q;
  end

endmodule

// File: tb/tb_amul_err_eval.sv
// Randomized/self-checking bench for amul_err_eval at W=4 (256-pair sweeps).
// z_approx comes from selectable behavioural multipliers; totals from a loop model.
`timescale 1ns/1ps
module tb_amul_err_eval;

  localparam int W = 4;
  localparam int N = 1 << (2*W);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   op_x, op_y;
  logic [2*W-1:0] z_approx;
  logic           busy, done;
  logic [4*W-1:0] sum_ed;
  logic [6*W-1:0] sum_sq;
  logic [2*W-1:0] max_ed;
  logic [2*W:0]   err_cnt;

  int             mode;
  logic [2*W-1:0] lut [N];
  int             n_chk;
  int             n_fail;

  amul_err_eval #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_x     (op_x),
    .op_y     (op_y),
    .z_approx (z_approx),
    .busy     (busy),
    .done     (done),
    .sum_ed   (sum_ed),
    .sum_sq   (sum_sq),
    .max_ed   (max_ed),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int zmodel(input int m, input int x, input int y);
    int p;
    p = x * y;
    case (m)
      0: return p;
      1: return 0;
      2: return N - 1;
      3: return p + 1;
      default: return int'(lut[x * (1 << W) + y]);
    endcase
  endfunction

  always_comb z_approx = (2*W)'(zmodel(mode, int'(op_x), int'(op_y)));

  task automatic chk(input string tag,
                     input longint unsigned got,
                     input longint unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int m,
                       output longint e_sum, output longint e_sq,
                       output longint e_max, output longint e_cnt);
    longint d;
    e_sum = 0; e_sq = 0; e_max = 0; e_cnt = 0;
    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++) begin
        d = longint'(x * y) - longint'(zmodel(m, x, y));
        if (d < 0) d = -d;
        e_sum += d;
        e_sq  += d * d;
        if (d > e_max) e_max = d;
        if (d != 0) e_cnt++;
      end
  endtask

  task automatic sweep(input string tag, input int inj);
    int     cyc, dcyc;
    longint e_sum, e_sq, e_max, e_cnt;
    model(mode, e_sum, e_sq, e_max, e_cnt);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc  = 1;
    dcyc = 0;
    while (dcyc == 0 && cyc < N + 20) begin
      chk({tag, "_busy"}, longint'(busy), longint'(cyc <= N + 2));
      if (done) dcyc = cyc;
      else begin
        start = (cyc == inj);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, dcyc, N + 3);
    chk({tag, "_sum_ed"},  sum_ed,  e_sum);
    chk({tag, "_sum_sq"},  sum_sq,  e_sq);
    chk({tag, "_max_ed"},  max_ed,  e_max);
    chk({tag, "_err_cnt"}, err_cnt, e_cnt);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_hold"}, sum_ed, e_sum);
    chk({tag, "_hold_op"}, {op_x, op_y}, N - 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op"},   {op_x, op_y}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sed"},  sum_ed, 0);
    chk({tag, "_ssq"},  sum_sq, 0);
    chk({tag, "_max"},  max_ed, 0);
    chk({tag, "_cnt"},  err_cnt, 0);
  endtask

  initial begin
    int ndone;
    n_chk  = 0;
    n_fail = 0;
    mode   = 0;
    start  = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < N; i++) lut[i] = (2*W)'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    mode = 0; sweep("exact", -1);
    mode = 1; sweep("zero", -1);
    mode = 2; sweep("ones", -1);
    mode = 3; sweep("plus1", -1);
    mode = 4; sweep("rand", -1);
    mode = 1; sweep("inject", 100);
    mode = 4; sweep("rand_again", -1);

    // abort a sweep with a one-cycle reset
    mode = 2;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_zero("midrst");
    ndone = 0;
    for (int i = 0; i < N + 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("midrst_quiet", ndone, 0);

    for (int i = 0; i < N; i++) lut[i] = (2*W)'($urandom);
    mode = 4; sweep("after_rst", -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
